uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 156 +++++++++++++++
 tb/tb_uart_rx.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1.
module uart_rx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       GLOBAL_CLK,
  input  logic       RESET,
  input  logic       RX,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic       FRAME_ERR,
  output logic       PARITY_ERR,
  output logic       BUSY
);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_e;
`endif

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

  state_e      state_q, state_d;
  logic        sync1_q, rx_s_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        perr_q, perr_d;
  logic        busy_q, busy_d;
  logic        par_bad_q, par_bad_d;
  logic [15:0] lim_m1;
  logic        sample;

  always_comb begin
    lim_m1    = (state_q == S_START) ? HALF_M1 : FULL_M1;
    sample    = (cnt_q == lim_m1);
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 16'd0;
        if (!rx_s_q) begin
          state_d   = S_START;
          bit_d     = 3'd0;
          par_bad_d = 1'b0;
        end
      end
      S_START: begin
        // Mid-start-bit check rejects glitches shorter than half a bit.
        if (sample) begin
          cnt_d   = 16'd0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (sample) begin
          cnt_d   = 16'd0;
          shreg_d = {rx_s_q, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (sample) begin
          cnt_d     = 16'd0;
          par_bad_d = ^{shreg_q, rx_s_q};
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (sample) begin
          cnt_d = 16'd0;
          if (rx_s_q) begin
            state_d = S_IDLE;
            if (par_bad_q) begin
              perr_d = 1'b1;
            end else begin
              valid_d = 1'b1;
              data_d  = shreg_q;
            end
          end else begin
            ferr_d  = 1'b1;
            perr_d  = par_bad_q;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = 16'd0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = 16'd0;
        state_d = S_IDLE;
      end
    endcase
    // BUSY is registered from the next state so it tracks state_q exactly.
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge GLOBAL_CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      cnt_q     <= 16'd0;
      bit_q     <= 3'd0;
      shreg_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      busy_q    <= 1'b0;
      par_bad_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= RX;
      rx_s_q    <= sync1_q;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      busy_q    <= busy_d;
      par_bad_q <= par_bad_d;
    end
  end

  assign DATA       = data_q;
  assign VALID      = valid_q;
  assign FRAME_ERR  = ferr_q;
  assign PARITY_ERR = perr_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed bench for uart_rx at CLKS_PER_BIT=8.
module tb_uart_rx;
  localparam int N = 8;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 2 + N/2 + 9*N + 1 + N;
  localparam int FRAME_BITS = 11;
`else
  localparam int LAT = 2 + N/2 + 9*N + 1;
  localparam int FRAME_BITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid, ferr, perr, busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_valid, n_ferr, n_perr, n_ovl, valid_cyc, t0;
  logic [7:0] vdata [4];

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .GLOBAL_CLK(clk), .RESET(rst), .RX(rx), .DATA(data),
    .VALID(valid), .FRAME_ERR(ferr), .PARITY_ERR(perr), .BUSY(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      if (n_valid < 4) vdata[n_valid] = data;
      n_valid = n_valid + 1;
      valid_cyc = cyc;
    end
    if (ferr) n_ferr = n_ferr + 1;
    if (perr) n_perr = n_perr + 1;
    if (valid && (ferr || perr)) n_ovl = n_ovl + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_valid = 0; n_ferr = 0; n_perr = 0; n_ovl = 0; valid_cyc = 0;
    for (int i = 0; i < 4; i++) vdata[i] = 8'h00;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    wait_cyc(N);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip);
    t0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^b ^ par_flip);
`else
    if (par_flip) rx = 1'b0;
`endif
    drive_bit(stop);
  endtask

  initial begin
    clr();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_ferr", 32'(ferr), 32'h0);
    chk("rst_perr", 32'(perr), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_data", 32'(data), 32'h00);
    chk("post_rst_valid", 32'(valid), 32'h0);
    chk("post_rst_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    wait_cyc(4);

    // single frame, latency
    clr();
    send_frame(8'hA5, 1'b1, 1'b0);
    wait_cyc(4);
    chk("a5_count", 32'(n_valid), 32'd1);
    chk("a5_data", 32'(vdata[0]), 32'hA5);
    chk("a5_latency", 32'(valid_cyc - t0), 32'(LAT));
    chk("a5_ferr", 32'(n_ferr), 32'd0);
    chk("a5_busy", 32'(busy), 32'h0);

    // back-to-back frames
    clr();
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    wait_cyc(4);
    chk("b2b_count", 32'(n_valid), 32'd2);
    chk("b2b_first", 32'(vdata[0]), 32'h3C);
    chk("b2b_second", 32'(vdata[1]), 32'hC3);
    chk("b2b_data", 32'(data), 32'hC3);

    // 2-cycle glitch
    clr();
    rx = 1'b0;
    wait_cyc(2);
    rx = 1'b1;
    wait_cyc(20);
    chk("glitch_valid", 32'(n_valid), 32'd0);
    chk("glitch_ferr", 32'(n_ferr), 32'd0);
    chk("glitch_data", 32'(data), 32'hC3);
    chk("glitch_busy", 32'(busy), 32'h0);

    // framing error then break
    clr();
    send_frame(8'h55, 1'b0, 1'b0);
    rx = 1'b0;
    wait_cyc(40 - N);
    chk("ferr_count", 32'(n_ferr), 32'd1);
    chk("ferr_valid", 32'(n_valid), 32'd0);
    chk("ferr_perr", 32'(n_perr), 32'd0);
    chk("ferr_data", 32'(data), 32'hC3);
    chk("break_busy", 32'(busy), 32'h1);
    rx = 1'b1;
    wait_cyc(5);
    chk("break_exit_busy", 32'(busy), 32'h0);
    clr();
    send_frame(8'h12, 1'b1, 1'b0);
    wait_cyc(4);
    chk("after_break_count", 32'(n_valid), 32'd1);
    chk("after_break_data", 32'(data), 32'h12);

    // reset during bit 4 of 0xFF
    clr();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    wait_cyc(3);
    rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(35 + (FRAME_BITS - 10) * N + 10);
    chk("midrst_valid", 32'(n_valid), 32'd0);
    chk("midrst_ferr", 32'(n_ferr), 32'd0);
    chk("midrst_data", 32'(data), 32'h00);
    chk("midrst_busy", 32'(busy), 32'h0);
    clr();
    send_frame(8'h81, 1'b1, 1'b0);
    wait_cyc(4);
    chk("midrst_next_count", 32'(n_valid), 32'd1);
    chk("midrst_next_data", 32'(data), 32'h81);

`ifdef UART_RX_PARITY_EN
    clr();
    send_frame(8'h07, 1'b1, 1'b1);
    wait_cyc(4);
    chk("par_bad_perr", 32'(n_perr), 32'd1);
    chk("par_bad_valid", 32'(n_valid), 32'd0);
    chk("par_bad_data", 32'(data), 32'h81);
    clr();
    send_frame(8'h07, 1'b1, 1'b0);
    wait_cyc(4);
    chk("par_ok_valid", 32'(n_valid), 32'd1);
    chk("par_ok_perr", 32'(n_perr), 32'd0);
    chk("par_ok_data", 32'(data), 32'h07);
`else
    chk("perr_tied", 32'(perr), 32'h0);
`endif
    chk("pulse_overlap", 32'(n_ovl), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
